gsram_dp_init: RTL



---
 rtl/gsram_dp_init.sv | 118 +++++++++++
 1 files changed

// File: rtl/gsram_dp_init.sv
// Dual-port synchronous SRAM with per-bit write masks, port-0-wins collision merge,
// read-first reads, optional output register and a zero-fill sweep after reset.
module gsram_dp_init #(
  parameter int ABITS   = 9,
  parameter int DBITS   = 32,
  parameter bit OUT_REG = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [ABITS-1:0] A0,
  input  logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] D0,
  input  logic [DBITS-1:0] D1,
  input  logic [DBITS-1:0] WEM0,
  input  logic [DBITS-1:0] WEM1,
  input  logic             WE0,
  input  logic             WE1,
  input  logic             CE0,
  input  logic             CE1,
  output logic [DBITS-1:0] Q0,
  output logic [DBITS-1:0] Q1,
  output logic             INIT_DONE
);

  localparam int N = 1 << ABITS;
  localparam logic [ABITS:0] LAST_PTR = (ABITS+1)'(N - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state_reg;
  logic [ABITS:0]   clr_ptr_reg;
  logic             init_done_reg;
  logic [DBITS-1:0] mem [N];

  logic [ABITS-1:0] addr [2];
  logic [DBITS-1:0] din  [2];
  logic [DBITS-1:0] wem  [2];
  logic             we   [2];
  logic             ce   [2];
  logic [DBITS-1:0] q_out [2];

  assign addr[0] = A0;
  assign addr[1] = A1;
  assign din[0]  = D0;
  assign din[1]  = D1;
  assign wem[0]  = WEM0;
  assign wem[1]  = WEM1;
  assign we[0]   = WE0;
  assign we[1]   = WE1;
  assign ce[0]   = CE0;
  assign ce[1]   = CE1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= CLEAR;
      clr_ptr_reg   <= '0;
      init_done_reg <= 1'b0;
    end else if (state_reg == CLEAR) begin
      clr_ptr_reg <= clr_ptr_reg + 1'b1;
      if (clr_ptr_reg == LAST_PTR) begin
        state_reg     <= READY;
        init_done_reg <= 1'b1;
      end
    end
  end

  // Port 1 is applied first so that port 0's later assignment wins on overlapping bits.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (state_reg == CLEAR) begin
        mem[clr_ptr_reg[ABITS-1:0]] <= '0;
      end else begin
        for (int p = 1; p >= 0; p--) begin
          if (ce[p] && we[p]) begin
            for (int i = 0; i < DBITS; i++) begin
              if (wem[p][i]) mem[addr[p]][i] <= din[p][i];
            end
          end
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DBITS-1:0] rd_reg;
      logic             rd_vld_reg;

      // Reads sample mem before this edge's writes land, giving read-first behaviour.
      always_ff @(posedge CLK) begin
        if (RST) begin
          rd_reg     <= '0;
          rd_vld_reg <= 1'b0;
        end else begin
          rd_vld_reg <= (state_reg == READY) && ce[gi] && !we[gi];
          if ((state_reg == READY) && ce[gi] && !we[gi]) rd_reg <= mem[addr[gi]];
        end
      end

      if (OUT_REG) begin : g_oreg
        logic [DBITS-1:0] q2_reg;
        always_ff @(posedge CLK) begin
          if (RST)             q2_reg <= '0;
          else if (rd_vld_reg) q2_reg <= rd_reg;
        end
        assign q_out[gi] = q2_reg;
      end else begin : g_noreg
        assign q_out[gi] = rd_reg;
      end
    end
  endgenerate

  assign Q0        = q_out[0];
  assign Q1        = q_out[1];
  assign INIT_DONE = init_done_reg;

endmodule
